// File: rtl/mash_ncc_combiner_pkg.sv
// Shared constants for the MASH noise-cancellation combiner: order encodings,
// y width and warm-up target.
package mash_ncc_combiner_pkg;

    localparam logic [1:0] ORDER_1   = 2'd1;
    localparam logic [1:0] ORDER_11  = 2'd2;
    localparam logic [1:0] ORDER_111 = 2'd3;

    localparam int unsigned Y_W = 4;

    localparam logic [1:0] WARMUP_TGT = 2'd2;

    typedef logic signed [Y_W-1:0] y_t;

    // Order code 0 is an alias for the full third-order path.
    function automatic logic [1:0] norm_order(input logic [1:0] order);
        return (order == 2'd0) ? ORDER_111 : order;
    endfunction

endpackage

// File: rtl/mash_ncc_combiner_if.sv
// Control/data bundle between the MASH modulator side and the combiner.
interface mash_ncc_combiner_if #(
    parameter int unsigned P_DIV_WIDTH = 8
);

    logic                   i_en;
    logic                   i_quantize1;
    logic                   i_quantize2;
    logic                   i_quantize3;
    logic [1:0]             i_order;
    logic [P_DIV_WIDTH-1:0] i_int_word;
    logic                   i_int_load;
    logic [P_DIV_WIDTH-1:0] o_div_ratio;
    logic [3:0]             o_y;
    logic                   o_valid;
    logic                   o_ovf;

    modport master (
        output i_en, i_quantize1, i_quantize2, i_quantize3, i_order, i_int_word, i_int_load,
        input  o_div_ratio, o_y, o_valid, o_ovf
    );

    modport slave (
        input  i_en, i_quantize1, i_quantize2, i_quantize3, i_order, i_int_word, i_int_load,
        output o_div_ratio, o_y, o_valid, o_ovf
    );

endinterface

// File: rtl/ncc_diff_stage.sv
// (1 - z^-1) differentiator; the delay register only advances when enabled.
module ncc_diff_stage
    import mash_ncc_combiner_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  y_t   i_x,
    output y_t   o_diff
);

    y_t x_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q <= '0;
        end else if (i_en) begin
            x_q <= i_x;
        end
    end

    assign o_diff = i_x - x_q;

endmodule

// File: rtl/mash_ncc_combiner.sv
// MASH 1-1-1 noise-cancellation combiner: registers N + y as the divide ratio.
// Define NCC_SAT_CHECK_EN to clamp to [P_DIV_MIN, 2^P_DIV_WIDTH-1] with sticky o_ovf.
module mash_ncc_combiner
    import mash_ncc_combiner_pkg::*;
#(
    parameter int unsigned P_DIV_WIDTH = 8,
    parameter int unsigned P_DIV_MIN   = 8
) (
    input logic                i_clk,
    input logic                i_rst,
    mash_ncc_combiner_if.slave bus
);

    localparam int unsigned W = P_DIV_WIDTH;

    logic [W-1:0] shadow_n_q;
    logic [W-1:0] active_n_q;
    logic [1:0]   shadow_order_q;
    logic [1:0]   active_order_q;
    logic [1:0]   warm_q;
    logic [1:0]   warm_d;
    logic [W-1:0] div_q;
    logic [W-1:0] div_d;
    y_t           y_q;
    y_t           y_d;

    y_t q1_ext;
    y_t q2_ext;
    y_t q3_ext;
    y_t d2;
    y_t d3a;
    y_t d3;

    assign q1_ext = {{(Y_W-1){1'b0}}, bus.i_quantize1};
    assign q2_ext = {{(Y_W-1){1'b0}}, bus.i_quantize2};
    assign q3_ext = {{(Y_W-1){1'b0}}, bus.i_quantize3};

    ncc_diff_stage u_diff2 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (bus.i_en),
        .i_x    (q2_ext),
        .o_diff (d2)
    );

    // Two cascaded differentiators give q3 - 2*q3d + q3dd.
    ncc_diff_stage u_diff3a (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (bus.i_en),
        .i_x    (q3_ext),
        .o_diff (d3a)
    );

    ncc_diff_stage u_diff3b (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (bus.i_en),
        .i_x    (d3a),
        .o_diff (d3)
    );

    always_comb begin
        y_d = q1_ext;
        case (active_order_q)
            ORDER_1:  y_d = q1_ext;
            ORDER_11: y_d = q1_ext + d2;
            default:  y_d = q1_ext + d2 + d3;
        endcase
    end

    always_comb begin
        warm_d = warm_q;
        if (shadow_order_q != active_order_q) begin
            warm_d = '0;
        end else if (warm_q != WARMUP_TGT) begin
            warm_d = warm_q + 2'd1;
        end
    end

`ifdef NCC_SAT_CHECK_EN
    localparam logic signed [W+1:0] DivMinS = (W+2)'(P_DIV_MIN);
    localparam logic signed [W+1:0] DivMaxS = {2'b00, {W{1'b1}}};

    logic signed [W+1:0] sum;
    logic                clamp;
    logic                ovf_q;

    always_comb begin
        sum   = $signed({2'b00, active_n_q}) + $signed({{(W+2-Y_W){y_d[Y_W-1]}}, y_d});
        clamp = 1'b1;
        if (sum < DivMinS) begin
            div_d = DivMinS[W-1:0];
        end else if (sum > DivMaxS) begin
            div_d = {W{1'b1}};
        end else begin
            div_d = sum[W-1:0];
            clamp = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (bus.i_en && clamp) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.o_ovf = ovf_q;
`else
    always_comb begin
        div_d = active_n_q + {{(W-Y_W){y_d[Y_W-1]}}, y_d};
    end

    assign bus.o_ovf = 1'b0;
`endif

    // Shadow capture ignores i_en; everything downstream freezes when i_en is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_n_q     <= '0;
            shadow_order_q <= ORDER_111;
            active_n_q     <= '0;
            active_order_q <= ORDER_111;
            warm_q         <= '0;
            div_q          <= '0;
            y_q            <= '0;
        end else begin
            if (bus.i_int_load) begin
                shadow_n_q     <= bus.i_int_word;
                shadow_order_q <= norm_order(bus.i_order);
            end
            if (bus.i_en) begin
                active_n_q     <= shadow_n_q;
                active_order_q <= shadow_order_q;
                warm_q         <= warm_d;
                div_q          <= div_d;
                y_q            <= y_d;
            end
        end
    end

    assign bus.o_div_ratio = div_q;
    assign bus.o_y         = y_q;
    assign bus.o_valid     = (warm_q == WARMUP_TGT);

endmodule

// File: tb/tb_mash_ncc_combiner.sv
// Directed bench for mash_ncc_combiner; expectations follow NCC_SAT_CHECK_EN when defined.
module tb_mash_ncc_combiner;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mash_ncc_combiner_if #(.P_DIV_WIDTH(8)) bus ();

    mash_ncc_combiner #(
        .P_DIV_WIDTH (8),
        .P_DIV_MIN   (8)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int y, input int div, input int valid);
        int ys;
        ys = $signed(bus.o_y);
        check({tag, ".y"}, ys, y);
        check({tag, ".div"}, int'(bus.o_div_ratio), div);
        check({tag, ".valid"}, int'(bus.o_valid), valid);
    endtask

    task automatic arm_load(input logic [7:0] word, input logic [1:0] ord);
        bus.i_int_load = 1'b1;
        bus.i_int_word = word;
        bus.i_order    = ord;
    endtask

    task automatic step(input logic en, input logic q1, input logic q2, input logic q3);
        bus.i_en        = en;
        bus.i_quantize1 = q1;
        bus.i_quantize2 = q2;
        bus.i_quantize3 = q3;
        @(posedge i_clk);
        #1;
        bus.i_int_load = 1'b0;
    endtask

    initial begin
        bus.i_en        = 1'b0;
        bus.i_quantize1 = 1'b0;
        bus.i_quantize2 = 1'b0;
        bus.i_quantize3 = 1'b0;
        bus.i_order     = 2'd3;
        bus.i_int_word  = '0;
        bus.i_int_load  = 1'b0;

        // Reset state
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_out("rst", 0, 0, 0);
        check("rst.ovf", int'(bus.o_ovf), 0);
        i_rst = 1'b0;

        // Load N=100 with i_en low: shadow captures, outputs hold
        arm_load(8'd100, 2'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_out("hold_load", 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("warm1", 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("warm2", 0, 100, 1);

        // Order 3 noise-cancellation sequence
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("o3_a", 0, 100, 1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_out("o3_b", 3, 103, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("o3_c", -3, 97, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("o3_d", 1, 101, 1);

        // Switch to order 1; q2/q3 random must not matter
        arm_load(8'd100, 2'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("o1_load", 0, 100, 1);
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("o1_e1.valid", int'(bus.o_valid), 0);
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check_out("o1_e2", 1, 101, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_out("o1_run", 1, 101, 1);
        end

        // Switch to order 2: valid low for two enabled edges
        arm_load(8'd100, 2'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_out("o2_load", 1, 101, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_out("o2_e1", 1, 101, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("o2_e2", 0, 100, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_out("o2_e3", 1, 101, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("o2_e4", -1, 99, 1);

        // Enable low for 5 cycles with q toggling: everything frozen
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_out("pre_hold", 1, 101, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, logic'(i[0]), 1'b0, ~logic'(i[0]));
            check_out("hold", 1, 101, 1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("resume", -1, 99, 1);

        // Back to order 3 with N=8 (order code 0 aliases order 3), then floor test
        arm_load(8'd8, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("n8_load", 0, 100, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("n8_e1", 0, 100, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("n8_e2", 0, 8, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_out("n8_q3", 1, 9, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef NCC_SAT_CHECK_EN
        check_out("floor", -2, 8, 1);
        check("floor.ovf", int'(bus.o_ovf), 1);
`else
        check_out("floor", -2, 6, 1);
        check("floor.ovf", int'(bus.o_ovf), 0);
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef NCC_SAT_CHECK_EN
        check("sticky.ovf", int'(bus.o_ovf), 1);
`else
        check("sticky.ovf", int'(bus.o_ovf), 0);
`endif
        check_out("after_floor", 1, 9, 1);

        // Load coincident with reset is discarded
        i_rst = 1'b1;
        arm_load(8'd50, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        i_rst = 1'b0;
        check_out("rst_load", 0, 0, 0);
        check("rst_load.ovf", int'(bus.o_ovf), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("rst_e1", 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("rst_e2", 0, 0, 1);

        // Two loads before transfer: last wins
        arm_load(8'd20, 2'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        arm_load(8'd30, 2'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("dbl_e1", 0, 0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("dbl_e2", 0, 30, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
